pc_sequencer: RTL and testbench

- Owns the program counter and sequences the PC+4 incrementer for the fetch stage of the RISC datapath.
- Each cycle it selects the next PC from one of: sequential increment, PC-relative branch, absolute/register jump, stall hold, or halt.
- Drives the instruction-memory address plus fetch-valid and flush qualifiers to the pipeline.
- Sits between the control unit/execute stage (redirect sources) and instruction memory.

---
 rtl/pc_sequencer_pkg.sv | 13 +
 rtl/pc_incr.sv | 11 +
 rtl/pc_sequencer.sv | 90 +++++++++
 tb/tb_pc_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-stage program counter sequencer.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] INSTR_BYTES          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_incr.sv
// Combinational one-instruction increment, modulo 2^32.
module pc_incr
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);

  assign y = a + INSTR_BYTES;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the fetch stage: selects sequential, branch,
// jump, stall or halt next-PC and qualifies the instruction fetch.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          OFF_W        = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_base,
  input  logic [OFF_W-1:0] br_offset,
  input  logic             jmp_en,
  input  logic [31:0]      jmp_target,
  input  logic             halt,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             flush,
  output logic             misalign,
  output logic [31:0]      fetch_count
);

  state_t      state;
  logic [31:0] br_link;
  logic [31:0] br_disp;
  logic [31:0] br_target;

  pc_incr u_seq_incr (
    .a (pc),
    .y (pc_plus4)
  );

  pc_incr u_br_incr (
    .a (br_base),
    .y (br_link)
  );

  // Word offset sign-extended and scaled to bytes.
  assign br_disp   = {{(32-OFF_W-2){br_offset[OFF_W-1]}}, br_offset, 2'b00};
  assign br_target = br_link + br_disp;

  assign fetch_valid = (state == RUN) && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      flush       <= 1'b0;
      misalign    <= 1'b0;
      fetch_count <= '0;
    end else begin
      flush <= 1'b0;
      if (fetch_valid) begin
        fetch_count <= fetch_count + 32'd1;
      end
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          // Redirects are downstream of the stall point, so they beat stall.
          if (halt) begin
            state <= HALT;
          end else if (jmp_en) begin
            pc    <= {jmp_target[31:2], 2'b00};
            flush <= 1'b1;
            if (jmp_target[1:0] != 2'b00) begin
              misalign <= 1'b1;
            end
          end else if (br_taken) begin
            pc    <= br_target;
            flush <= 1'b1;
          end else if (!stall) begin
            pc <= pc_plus4;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus a wrap-around instance.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_base;
  logic [21:0] br_offset;
  logic        jmp_en;
  logic [31:0] jmp_target;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;
  logic        misalign;
  logic [31:0] fetch_count;

  logic        rst_w;
  logic [31:0] pc_w;
  logic [31:0] pc_plus4_w;
  logic        fetch_valid_w;
  logic        flush_w;
  logic        misalign_w;
  logic [31:0] fetch_count_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .OFF_W(22)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_base     (br_base),
    .br_offset   (br_offset),
    .jmp_en      (jmp_en),
    .jmp_target  (jmp_target),
    .halt        (halt),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .misalign    (misalign),
    .fetch_count (fetch_count)
  );

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8), .OFF_W(22)) u_wrap (
    .clk         (clk),
    .rst         (rst_w),
    .stall       (1'b0),
    .br_taken    (1'b0),
    .br_base     (32'h0),
    .br_offset   (22'h0),
    .jmp_en      (1'b0),
    .jmp_target  (32'h0),
    .halt        (1'b0),
    .pc          (pc_w),
    .pc_plus4    (pc_plus4_w),
    .fetch_valid (fetch_valid_w),
    .flush       (flush_w),
    .misalign    (misalign_w),
    .fetch_count (fetch_count_w)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] base;
    logic [21:0] off;
    logic        jmp;
    logic [31:0] tgt;
    logic        hlt;
    logic [31:0] e_pc;
    logic        e_fv;
    logic        e_fl;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic s, logic b, logic [31:0] bb, logic [21:0] bo,
                              logic j, logic [31:0] jt, logic h,
                              logic [31:0] epc, logic efv, logic efl, logic emis,
                              logic [31:0] ecnt);
    vec_t v;
    v.stall = s;   v.br = b;     v.base = bb;  v.off = bo;
    v.jmp = j;     v.tgt = jt;   v.hlt = h;
    v.e_pc = epc;  v.e_fv = efv; v.e_fl = efl; v.e_mis = emis; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got 0x%08h want 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; br_taken = 0; br_base = '0; br_offset = '0;
    jmp_en = 0; jmp_target = '0; halt = 0;
  endtask

  task automatic check_main(input int idx, input logic [31:0] epc, input logic efv,
                            input logic efl, input logic emis, input logic [31:0] ecnt);
    chk("pc", idx, pc, epc);
    chk("pc_plus4", idx, pc_plus4, epc + 32'd4);
    chk("fetch_valid", idx, {31'b0, fetch_valid}, {31'b0, efv});
    chk("flush", idx, {31'b0, flush}, {31'b0, efl});
    chk("misalign", idx, {31'b0, misalign}, {31'b0, emis});
    chk("fetch_count", idx, fetch_count, ecnt);
  endtask

  logic [31:0] wrap_pc[4];

  initial begin
    //              stl br base      off          jmp tgt        hlt  pc        fv fl mis cnt
    vecs[0]  = mk(0, 0, 32'h0,  22'h0,       0, 32'h0,   0, 32'h000, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,  22'h0,       0, 32'h0,   0, 32'h000, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 32'h0,  22'h0,       0, 32'h0,   0, 32'h004, 1, 0, 0, 1);
    vecs[3]  = mk(0, 0, 32'h0,  22'h0,       0, 32'h0,   0, 32'h008, 1, 0, 0, 2);
    vecs[4]  = mk(0, 0, 32'h0,  22'h0,       0, 32'h0,   0, 32'h00C, 1, 0, 0, 3);
    vecs[5]  = mk(1, 0, 32'h0,  22'h0,       0, 32'h0,   0, 32'h010, 0, 0, 0, 4);
    vecs[6]  = mk(1, 0, 32'h0,  22'h0,       0, 32'h0,   0, 32'h010, 0, 0, 0, 4);
    vecs[7]  = mk(0, 0, 32'h0,  22'h0,       0, 32'h0,   0, 32'h010, 1, 0, 0, 4);
    vecs[8]  = mk(1, 1, 32'h20, 22'h3FFFFD,  0, 32'h0,   0, 32'h014, 0, 0, 0, 5);
    vecs[9]  = mk(0, 0, 32'h0,  22'h0,       0, 32'h0,   0, 32'h018, 1, 1, 0, 5);
    vecs[10] = mk(0, 1, 32'h20, 22'h5,       1, 32'h103, 0, 32'h01C, 1, 0, 0, 6);
    vecs[11] = mk(0, 0, 32'h0,  22'h0,       0, 32'h0,   0, 32'h100, 1, 1, 1, 7);
    vecs[12] = mk(0, 0, 32'h0,  22'h0,       0, 32'h0,   0, 32'h104, 1, 0, 1, 8);
    vecs[13] = mk(0, 0, 32'h0,  22'h0,       1, 32'h40,  0, 32'h108, 1, 0, 1, 9);
    vecs[14] = mk(0, 0, 32'h0,  22'h0,       0, 32'h0,   1, 32'h040, 1, 1, 1, 10);
    vecs[15] = mk(0, 0, 32'h0,  22'h0,       1, 32'h200, 0, 32'h040, 0, 0, 1, 11);
    vecs[16] = mk(1, 1, 32'h80, 22'h1,       0, 32'h0,   0, 32'h040, 0, 0, 1, 11);
    vecs[17] = mk(0, 0, 32'h0,  22'h0,       0, 32'h0,   0, 32'h040, 0, 0, 1, 11);

    idle_inputs();
    rst = 1; rst_w = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 18; i++) begin
      stall = vecs[i].stall; br_taken = vecs[i].br; br_base = vecs[i].base;
      br_offset = vecs[i].off; jmp_en = vecs[i].jmp; jmp_target = vecs[i].tgt;
      halt = vecs[i].hlt;
      #3;
      check_main(i, vecs[i].e_pc, vecs[i].e_fv, vecs[i].e_fl, vecs[i].e_mis, vecs[i].e_cnt);
      @(posedge clk); #1;
    end

    // Reset out of HALT while stall and jump are also asserted.
    stall = 1; jmp_en = 1; jmp_target = 32'h301; halt = 1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; idle_inputs();
    #3 check_main(100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    #3 check_main(101, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    #3 check_main(102, 32'h4, 1'b1, 1'b0, 1'b0, 32'h1);

    // Wrap-around instance: BOOT, then FFFF_FFF8, FFFF_FFFC, 0.
    wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFF8;
    wrap_pc[2] = 32'hFFFF_FFFC; wrap_pc[3] = 32'h0000_0000;
    @(posedge clk); #1 rst_w = 0;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("wrap_pc", i, pc_w, wrap_pc[i]);
      chk("wrap_pc_plus4", i, pc_plus4_w, wrap_pc[i] + 32'd4);
      chk("wrap_fetch_valid", i, {31'b0, fetch_valid_w}, (i == 0) ? 32'd0 : 32'd1);
      chk("wrap_flush", i, {31'b0, flush_w}, 32'd0);
      chk("wrap_misalign", i, {31'b0, misalign_w}, 32'd0);
      chk("wrap_fetch_count", i, fetch_count_w, (i == 0) ? 32'd0 : 32'(i - 1));
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
